// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer datapath and its control FSM.
//   - field widths and moduli of the ms/sec/min/hr count fields
//   - *_MAX constants (largest legal value of each field)
//   - counter operation encoding plus its priority decoder
package timer_pkg;

    localparam int MS_W  = 10;
    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    localparam int MS_MOD  = 1000;
    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int HR_MOD  = 24;

    localparam logic [MS_W-1:0]  MS_MAX  = MS_W'(MS_MOD - 1);
    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(SEC_MOD - 1);
    localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(MIN_MOD - 1);
    localparam logic [HR_W-1:0]  HR_MAX  = HR_W'(HR_MOD - 1);

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_UP   = 2'd1,
        CNT_DOWN = 2'd2,
        CNT_CLR  = 2'd3
    } cnt_op_e;

    // Clear wins over everything; up and down together cancel to a hold.
    function automatic cnt_op_e decode_op(input logic clr, input logic up, input logic down);
        cnt_op_e op;
        if (clr)
            op = CNT_CLR;
        else if (up && !down)
            op = CNT_UP;
        else if (down && !up)
            op = CNT_DOWN;
        else
            op = CNT_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter used for every timer count field.
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset, count -> 0
//   i_clr    clear count to 0 next cycle (beats up/down)
//   i_up     increment, MODULUS-1 wraps to 0
//   i_down   decrement, 0 wraps to MODULUS-1
//   o_count  registered count, always in 0..MODULUS-1
//   o_zero   count == 0
module mod_n_updown_counter
    import timer_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int MODULUS = 60
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_up,
    input  logic             i_down,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    cnt_op_e          op;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        op         = decode_op(i_clr, i_up, i_down);
        count_next = o_count;
        case (op)
            CNT_CLR:  count_next = '0;
            CNT_UP:   count_next = (o_count == TOP) ? '0 : o_count + ONE;
            CNT_DOWN: count_next = (o_count == '0) ? TOP : o_count - ONE;
            default:  count_next = o_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_count <= '0;
        else
            o_count <= count_next;
    end

    assign o_zero = (o_count == '0);

endmodule

// File: rtl/timer_count_chain.sv
// Countdown-timer count datapath sitting under the timer control FSM.
// Holds the ms/sec/min/hr fields, applies the FSM's per-field commands,
// paces run-mode ms decrements with a 1 ms prescaler, and hands the
// count and borrow strobes back to the FSM (which closes the down cascade).
// Ports:
//   i_clk, i_rst                  clock / synchronous active-high reset
//   i_ms_up                       clear ms field
//   i_ms_down                     run: decrement ms on each 1 ms tick
//   i_{sec,min,hr}_{up,down}      per-cycle field increment/decrement
//   o_ms, o_sec, o_min, o_hr      registered count fields
//   o_{ms,sec,min}_borrowdown     combinational borrow strobes
//   o_tick                        combinational 1 ms prescaler tick
module timer_count_chain
    import timer_pkg::*;
#(
    parameter int CLK_PER_MS = 1000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ms_up,
    input  logic             i_ms_down,
    input  logic             i_sec_up,
    input  logic             i_sec_down,
    input  logic             i_min_up,
    input  logic             i_min_down,
    input  logic             i_hr_up,
    input  logic             i_hr_down,
    output logic [MS_W-1:0]  o_ms,
    output logic [SEC_W-1:0] o_sec,
    output logic [MIN_W-1:0] o_min,
    output logic [HR_W-1:0]  o_hr,
    output logic             o_ms_borrowdown,
    output logic             o_sec_borrowdown,
    output logic             o_min_borrowdown,
    output logic             o_tick
);

    localparam int               PRE_W   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_MS - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [PRE_W-1:0] presc;
    logic             tick;
    logic             ms_zero;
    logic             sec_zero;
    logic             min_zero;
    logic             hr_zero_unused;

    // Prescaler only runs while the FSM asserts run, and snaps back to 0
    // otherwise, so every run start sees the full CLK_PER_MS latency.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_ms_down)
            presc <= '0;
        else if (presc == PRE_MAX)
            presc <= '0;
        else
            presc <= presc + PRE_ONE;
    end

    // Strobes are forced low during reset so all outputs read 0 then.
    assign tick = ~i_rst & i_ms_down & (presc == PRE_MAX);

    mod_n_updown_counter #(
        .WIDTH   (MS_W),
        .MODULUS (MS_MOD)
    ) u_ms (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_ms_up),
        .i_up    (1'b0),
        .i_down  (tick),
        .o_count (o_ms),
        .o_zero  (ms_zero)
    );

    mod_n_updown_counter #(
        .WIDTH   (SEC_W),
        .MODULUS (SEC_MOD)
    ) u_sec (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (1'b0),
        .i_up    (i_sec_up),
        .i_down  (i_sec_down),
        .o_count (o_sec),
        .o_zero  (sec_zero)
    );

    mod_n_updown_counter #(
        .WIDTH   (MIN_W),
        .MODULUS (MIN_MOD)
    ) u_min (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (1'b0),
        .i_up    (i_min_up),
        .i_down  (i_min_down),
        .o_count (o_min),
        .o_zero  (min_zero)
    );

    // Hours are the top of the chain: nothing consumes an hour borrow.
    mod_n_updown_counter #(
        .WIDTH   (HR_W),
        .MODULUS (HR_MOD)
    ) u_hr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (1'b0),
        .i_up    (i_hr_up),
        .i_down  (i_hr_down),
        .o_count (o_hr),
        .o_zero  (hr_zero_unused)
    );

    // A borrow is raised only when the field really decrements through 0:
    // a clear (ms) or a cancelling up command (sec/min) suppresses it.
    assign o_tick           = tick;
    assign o_ms_borrowdown  = tick & ~i_ms_up & ms_zero;
    assign o_sec_borrowdown = ~i_rst & i_sec_down & ~i_sec_up & sec_zero;
    assign o_min_borrowdown = ~i_rst & i_min_down & ~i_min_up & min_zero;

endmodule

// File: tb/tb_timer_count_chain.sv
module tb_timer_count_chain;

    localparam int CPM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ms_up, ms_down, sec_up, sec_down_c, min_up, min_down_c, hr_up, hr_down_c, casc;
    logic sec_down, min_down, hr_down;
    logic [9:0] o_ms;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hr;
    logic o_ms_b, o_sec_b, o_min_b, o_tick;

    // Model control FSM: optionally feeds each borrow back as the next field's down.
    assign sec_down = sec_down_c | (casc & o_ms_b);
    assign min_down = min_down_c | (casc & o_sec_b);
    assign hr_down  = hr_down_c  | (casc & o_min_b);

    timer_count_chain #(.CLK_PER_MS(CPM)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_ms_up          (ms_up),
        .i_ms_down        (ms_down),
        .i_sec_up         (sec_up),
        .i_sec_down       (sec_down),
        .i_min_up         (min_up),
        .i_min_down       (min_down),
        .i_hr_up          (hr_up),
        .i_hr_down        (hr_down),
        .o_ms             (o_ms),
        .o_sec            (o_sec),
        .o_min            (o_min),
        .o_hr             (o_hr),
        .o_ms_borrowdown  (o_ms_b),
        .o_sec_borrowdown (o_sec_b),
        .o_min_borrowdown (o_min_b),
        .o_tick           (o_tick)
    );

    typedef struct packed {
        logic [9:0] ms;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hr;
    } cnt_t;

    cnt_t exp_q[$];
    int   m_ms = 0, m_sec = 0, m_min = 0, m_hr = 0, m_presc = 0;
    bit   mon_on = 1'b0;
    int   total = 0;
    int   bad = 0;

    function automatic int upd(input int v, input bit up, input bit dn, input int m);
        if (up && !dn) return (v == m - 1) ? 0 : v + 1;
        if (dn && !up) return (v == 0) ? m - 1 : v - 1;
        return v;
    endfunction

    // Reference model: predicts strobes for this cycle and pushes next counts.
    always @(negedge clk) begin : model
        bit   p_tick, p_msb, p_secdn, p_secb, p_mindn, p_minb, p_hrdn;
        int   n_ms, n_sec, n_min, n_hr, n_presc;
        cnt_t e;
        if (mon_on) begin
            p_tick  = ms_down && (m_presc == CPM - 1) && !rst;
            p_msb   = p_tick && !ms_up && (m_ms == 0);
            p_secdn = sec_down_c || (casc && p_msb);
            p_secb  = p_secdn && !sec_up && (m_sec == 0) && !rst;
            p_mindn = min_down_c || (casc && p_secb);
            p_minb  = p_mindn && !min_up && (m_min == 0) && !rst;
            p_hrdn  = hr_down_c || (casc && p_minb);
            if (!rst) begin
                total++;
                if ({o_tick, o_ms_b, o_sec_b, o_min_b} !== {p_tick, p_msb, p_secb, p_minb}) begin
                    bad++;
                    $display("FAIL strobes t=%0t: tick/msb/secb/minb got %b%b%b%b expected %b%b%b%b",
                             $time, o_tick, o_ms_b, o_sec_b, o_min_b, p_tick, p_msb, p_secb, p_minb);
                end
            end
            if (rst) begin
                n_ms = 0; n_sec = 0; n_min = 0; n_hr = 0; n_presc = 0;
            end else begin
                n_ms    = ms_up ? 0 : (p_tick ? ((m_ms == 0) ? 999 : m_ms - 1) : m_ms);
                n_sec   = upd(m_sec, sec_up, p_secdn, 60);
                n_min   = upd(m_min, min_up, p_mindn, 60);
                n_hr    = upd(m_hr, hr_up, p_hrdn, 24);
                n_presc = !ms_down ? 0 : ((m_presc == CPM - 1) ? 0 : m_presc + 1);
            end
            e.ms = 10'(n_ms); e.sec = 6'(n_sec); e.min = 6'(n_min); e.hr = 5'(n_hr);
            exp_q.push_back(e);
            m_ms = n_ms; m_sec = n_sec; m_min = n_min; m_hr = n_hr; m_presc = n_presc;
        end
    end

    // Scoreboard: compare registered counts one step after each edge.
    always @(posedge clk) begin
        #1;
        if (mon_on && exp_q.size() > 0) begin : sb
            cnt_t e;
            e = exp_q.pop_front();
            total++;
            if ({o_ms, o_sec, o_min, o_hr} !== e) begin
                bad++;
                $display("FAIL counts t=%0t: got %0d:%0d:%0d.%0d expected %0d:%0d:%0d.%0d",
                         $time, o_hr, o_min, o_sec, o_ms, e.hr, e.min, e.sec, e.ms);
            end
        end
    end

    task automatic idle();
        rst = 0; ms_up = 0; ms_down = 0; sec_up = 0; sec_down_c = 0;
        min_up = 0; min_down_c = 0; hr_up = 0; hr_down_c = 0; casc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        step();
        mon_on = 1'b1;
        rst = 0;
        total++;
        if ({o_ms, o_sec, o_min, o_hr} !== 27'd0) begin
            bad++; $display("FAIL reset_init: got %h expected 0", {o_ms, o_sec, o_min, o_hr});
        end
        sec_up = 1; min_up = 1; hr_up = 1;
        step(); step();
        idle();
        rst = 1;
        step();
        rst = 0;
        total++;
        if ({o_ms, o_sec, o_min, o_hr} !== 27'd0) begin
            bad++; $display("FAIL reset_clear: got %h expected 0", {o_ms, o_sec, o_min, o_hr});
        end
        @(negedge clk);
        total++;
        if ({o_tick, o_ms_b, o_sec_b, o_min_b} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes: got %b expected 0000", {o_tick, o_ms_b, o_sec_b, o_min_b});
        end
        step();
        begin : no_tick
            logic seen;
            seen = 1'b0;
            ms_down = 1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                seen = seen | o_tick;
                step();
            end
            ms_down = 0;
            total++;
            if (seen !== 1'b0) begin
                bad++; $display("FAIL reset_3cyc_tick: got %b expected 0", seen);
            end
        end
        step();
    endtask

    task automatic test_prescaler();
        logic [9:0] ticks;
        logic [9:0] msv [1:10];
        idle();
        ms_up = 1;
        step();
        ms_up = 0;
        ms_down = 1;
        for (int i = 0; i < 5000 && o_ms != 10'd5; i++) step();
        ms_down = 0;
        step();
        total++;
        if (o_ms !== 10'd5) begin
            bad++; $display("FAIL presc_setup: got ms=%0d expected 5", o_ms);
        end
        ticks = '0;
        ms_down = 1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            ticks[c-1] = o_tick;
            step();
            msv[c] = o_ms;
        end
        total++;
        if (ticks[7:0] !== 8'b1000_1000) begin
            bad++; $display("FAIL presc_ticks: got %b expected 10001000", ticks[7:0]);
        end
        total++;
        if (msv[4] !== 10'd4 || msv[8] !== 10'd3) begin
            bad++; $display("FAIL presc_ms: got %0d,%0d expected 4,3", msv[4], msv[8]);
        end
        ticks = '0;
        for (int c = 1; c <= 10; c++) begin
            ms_down = (c != 6);
            @(negedge clk);
            ticks[c-1] = o_tick;
            step();
        end
        total++;
        if (ticks !== 10'b10_0000_1000) begin
            bad++; $display("FAIL presc_restart: got %b expected 1000001000", ticks);
        end
        total++;
        if (o_ms !== 10'd1) begin
            bad++; $display("FAIL presc_restart_ms: got %0d expected 1", o_ms);
        end
        idle();
        step();
    endtask

    task automatic test_cascade();
        idle();
        rst = 1; step(); rst = 0;
        hr_up = 1; step(); hr_up = 0;
        total++;
        if ({o_hr, o_min, o_sec, o_ms} !== {5'd1, 6'd0, 6'd0, 10'd0}) begin
            bad++; $display("FAIL casc_setup: got %0d:%0d:%0d.%0d expected 1:0:0.0", o_hr, o_min, o_sec, o_ms);
        end
        casc = 1; ms_down = 1;
        step(); step(); step();
        @(negedge clk);
        total++;
        if ({o_tick, o_ms_b, o_sec_b, o_min_b} !== 4'b1111) begin
            bad++; $display("FAIL casc_borrows: got %b expected 1111", {o_tick, o_ms_b, o_sec_b, o_min_b});
        end
        step();
        total++;
        if ({o_hr, o_min, o_sec, o_ms} !== {5'd0, 6'd59, 6'd59, 10'd999}) begin
            bad++; $display("FAIL casc_result: got %0d:%0d:%0d.%0d expected 0:59:59.999", o_hr, o_min, o_sec, o_ms);
        end
        idle();
        step();
    endtask

    task automatic test_set_wrap();
        idle();
        rst = 1; step(); rst = 0;
        min_down_c = 1;
        @(negedge clk);
        total++;
        if (o_min_b !== 1'b1) begin
            bad++; $display("FAIL min_borrow: got %b expected 1", o_min_b);
        end
        step();
        min_down_c = 0;
        total++;
        if (o_min !== 6'd59) begin
            bad++; $display("FAIL min_wrap: got %0d expected 59", o_min);
        end
        sec_down_c = 1; step(); sec_down_c = 0;
        sec_up = 1; step(); sec_up = 0;
        total++;
        if (o_sec !== 6'd0 || o_min !== 6'd59) begin
            bad++; $display("FAIL sec_wrap: got sec=%0d min=%0d expected sec=0 min=59", o_sec, o_min);
        end
        hr_down_c = 1; step(); hr_down_c = 0;
        total++;
        if (o_hr !== 5'd23) begin
            bad++; $display("FAIL hr_wrap_down: got %0d expected 23", o_hr);
        end
        hr_up = 1; step(); hr_up = 0;
        total++;
        if (o_hr !== 5'd0) begin
            bad++; $display("FAIL hr_wrap_up: got %0d expected 0", o_hr);
        end
    endtask

    task automatic test_simultaneous();
        idle();
        sec_up = 1; step(); step(); step();
        sec_down_c = 1; step();
        idle();
        total++;
        if (o_sec !== 6'd3) begin
            bad++; $display("FAIL sec_hold: got %0d expected 3", o_sec);
        end
        rst = 1; step(); rst = 0;
        ms_down = 1;
        step(); step(); step();
        ms_up = 1;
        @(negedge clk);
        total++;
        if ({o_tick, o_ms_b} !== 2'b10) begin
            bad++; $display("FAIL msup_tick: tick/borrow got %b%b expected 10", o_tick, o_ms_b);
        end
        step();
        total++;
        if (o_ms !== 10'd0) begin
            bad++; $display("FAIL msup_clear: got %0d expected 0", o_ms);
        end
        idle();
        step();
    endtask

    task automatic test_reset_midrun();
        logic [3:0] ticks;
        idle();
        rst = 1; step(); rst = 0;
        sec_up = 1; for (int i = 0; i < 5; i++) step(); sec_up = 0;
        ms_down = 1;
        step(); step(); step();
        rst = 1;
        step();
        rst = 0;
        total++;
        if ({o_ms, o_sec, o_min, o_hr} !== 27'd0) begin
            bad++; $display("FAIL midrun_reset: got %0d:%0d:%0d.%0d expected 0:0:0.0", o_hr, o_min, o_sec, o_ms);
        end
        ticks = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            ticks[c-1] = o_tick;
            step();
        end
        total++;
        if (ticks !== 4'b1000 || o_ms !== 10'd999) begin
            bad++; $display("FAIL midrun_restart: ticks got %b ms=%0d expected 1000 ms=999", ticks, o_ms);
        end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 39) == 0);
            ms_up      = ($urandom_range(0, 7) == 0);
            ms_down    = ($urandom_range(0, 3) != 0);
            sec_up     = ($urandom_range(0, 3) == 0);
            sec_down_c = ($urandom_range(0, 3) == 0);
            min_up     = ($urandom_range(0, 3) == 0);
            min_down_c = ($urandom_range(0, 3) == 0);
            hr_up      = ($urandom_range(0, 3) == 0);
            hr_down_c  = ($urandom_range(0, 3) == 0);
            if (i % 50 == 0) casc = $urandom_range(0, 1);
            step();
        end
        idle();
        step(); step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_prescaler();
        test_cascade();
        test_set_wrap();
        test_simultaneous();
        test_reset_midrun();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
